// File: rtl/boreal_vec_pkg.sv
// Shared definitions for the boreal vector lane and its issuing sequencer.
//   OP_*      : lane opcodes carried on lane_op
//   seq_st_t  : sequencer state encoding
//   seq_cfg_t : command fields held for the lifetime of one command
package boreal_vec_pkg;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_MAC      = 3'd1;
  localparam logic [2:0] OP_SCALE    = 3'd2;
  localparam logic [2:0] OP_CLAMP    = 3'd3;
  localparam logic [2:0] OP_LOAD_ACC = 3'd4;
  localparam logic [2:0] OP_ZERO_ACC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ZERO   = 3'd1,
    ST_MAC    = 3'd2,
    ST_SCALE  = 3'd3,
    ST_CLAMP  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_RESULT = 3'd6
  } seq_st_t;

  typedef struct packed {
    logic        do_scale;
    logic        do_clamp;
    logic [15:0] scale;
    logic [15:0] zero_pt;
    logic [31:0] cmin;
    logic [31:0] cmax;
  } seq_cfg_t;

endpackage

// File: rtl/boreal_vec_seq.sv
// Issuing sequencer for one boreal vector lane.
// Takes a dot-product command, then streams int8 (a,b) pairs into the lane as
// ZERO_ACC, len x MAC, optional SCALE, optional CLAMP. The lane accumulator is
// captured one cycle after the last enabled lane op and returned on a
// valid/ready result port.
// Ports:
//   clk, rst_n (async, active low), abort (sync, drops the current command)
//   cmd_*   : command handshake and fields (latched on accept)
//   op_*    : operand stream, consumed only in MAC
//   lane_*  : lane control out, lane_acc/lane_done in
//   res_*   : result handshake; res_data holds the captured accumulator
//   busy    : not idle
//   err     : sticky, lane_done missing in DRAIN; cleared on next cmd accept
module boreal_vec_seq
  import boreal_vec_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_do_scale,
  input  logic             cmd_do_clamp,
  input  logic [15:0]      cmd_scale,
  input  logic [15:0]      cmd_zero_pt,
  input  logic [31:0]      cmd_cmin,
  input  logic [31:0]      cmd_cmax,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic             lane_en,
  output logic [2:0]       lane_op,
  output logic [7:0]       lane_a,
  output logic [7:0]       lane_b,
  output logic [15:0]      lane_scale,
  output logic [15:0]      lane_zero_pt,
  output logic [31:0]      lane_cmin,
  output logic [31:0]      lane_cmax,
  input  logic [31:0]      lane_acc,
  input  logic             lane_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             busy,
  output logic             err
);

  seq_st_t          state, state_nxt;
  seq_cfg_t         cfg;
  logic [LEN_W-1:0] remain;
  logic             cmd_acc;
  logic             op_hs;
  seq_st_t          post_mac;

  // abort masks every handshake in its cycle, including in IDLE
  assign cmd_acc = (state == ST_IDLE) && cmd_valid && !abort;
  assign op_hs   = (state == ST_MAC) && op_valid && !abort;

  // first enabled post-MAC step; cfg is already latched by the ZERO cycle
  assign post_mac = cfg.do_scale ? ST_SCALE :
                    cfg.do_clamp ? ST_CLAMP : ST_DRAIN;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    if (abort && state != ST_IDLE) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (cmd_acc) state_nxt = ST_ZERO;
        ST_ZERO:   state_nxt = (remain != '0) ? ST_MAC : post_mac;
        ST_MAC:    if (op_hs && remain == LEN_W'(1)) state_nxt = post_mac;
        ST_SCALE:  state_nxt = cfg.do_clamp ? ST_CLAMP : ST_DRAIN;
        ST_CLAMP:  state_nxt = ST_DRAIN;
        ST_DRAIN:  state_nxt = ST_RESULT;
        ST_RESULT: if (res_ready) state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    cmd_ready = (state == ST_IDLE) && !abort;
    op_ready  = (state == ST_MAC) && !abort;
    res_valid = (state == ST_RESULT) && !abort;
    lane_en   = 1'b0;
    lane_op   = OP_NOP;
    lane_a    = '0;
    lane_b    = '0;
    if (!abort) begin
      case (state)
        ST_ZERO: begin
          lane_en = 1'b1;
          lane_op = OP_ZERO_ACC;
        end
        ST_MAC: begin
          // operands pass straight through; a gap on op_valid idles the lane
          lane_en = op_valid;
          lane_op = OP_MAC;
          lane_a  = op_a;
          lane_b  = op_b;
        end
        ST_SCALE: begin
          lane_en = 1'b1;
          lane_op = OP_SCALE;
        end
        ST_CLAMP: begin
          lane_en = 1'b1;
          lane_op = OP_CLAMP;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign lane_scale   = cfg.scale;
  assign lane_zero_pt = cfg.zero_pt;
  assign lane_cmin    = cfg.cmin;
  assign lane_cmax    = cfg.cmax;

  // command capture, element countdown, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg      <= '0;
      remain   <= '0;
      res_data <= '0;
      err      <= 1'b0;
    end else begin
      if (cmd_acc) begin
        cfg <= '{do_scale: cmd_do_scale, do_clamp: cmd_do_clamp,
                 scale: cmd_scale, zero_pt: cmd_zero_pt,
                 cmin: cmd_cmin, cmax: cmd_cmax};
        remain <= cmd_len;
        err    <= 1'b0;
      end
      if (op_hs) remain <= remain - LEN_W'(1);
      // DRAIN follows the last enabled lane cycle, so lane_done must be up
      if (state == ST_DRAIN && !abort) begin
        res_data <= lane_acc;
        if (!lane_done) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_boreal_vec_seq.sv
// Bench for boreal_vec_seq paired with a behavioural lane.
module tb_boreal_vec_seq;
  import boreal_vec_pkg::*;

  localparam int LEN_W = 16;

  logic             clk, rst_n, abort;
  logic             cmd_valid, cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_do_scale, cmd_do_clamp;
  logic [15:0]      cmd_scale, cmd_zero_pt;
  logic [31:0]      cmd_cmin, cmd_cmax;
  logic             op_valid, op_ready;
  logic [7:0]       op_a, op_b;
  logic             lane_en;
  logic [2:0]       lane_op;
  logic [7:0]       lane_a, lane_b;
  logic [15:0]      lane_scale, lane_zero_pt;
  logic [31:0]      lane_cmin, lane_cmax, lane_acc;
  logic             lane_done;
  logic             res_valid, res_ready;
  logic [31:0]      res_data;
  logic             busy, err;

  int n_chk, n_fail;
  logic [7:0] opa [0:63];
  logic [7:0] opb [0:63];

  boreal_vec_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_do_scale(cmd_do_scale), .cmd_do_clamp(cmd_do_clamp),
    .cmd_scale(cmd_scale), .cmd_zero_pt(cmd_zero_pt),
    .cmd_cmin(cmd_cmin), .cmd_cmax(cmd_cmax),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .lane_en(lane_en), .lane_op(lane_op), .lane_a(lane_a), .lane_b(lane_b),
    .lane_scale(lane_scale), .lane_zero_pt(lane_zero_pt),
    .lane_cmin(lane_cmin), .lane_cmax(lane_cmax),
    .lane_acc(lane_acc), .lane_done(lane_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural lane: acc updates on enabled cycles, done one cycle later
  logic [31:0] acc_m;
  logic        done_m;
  longint      lane_nxt;
  always_comb begin
    lane_nxt = longint'($signed(acc_m));
    case (lane_op)
      OP_MAC:      lane_nxt = longint'($signed(acc_m)) +
                              longint'($signed(lane_a)) * longint'($signed(lane_b));
      OP_SCALE:    lane_nxt = ((longint'($signed(acc_m)) * longint'({16'd0, lane_scale})) >>> 16)
                              + longint'($signed(lane_zero_pt));
      OP_CLAMP: begin
        if ($signed(acc_m) > $signed(lane_cmax))      lane_nxt = longint'($signed(lane_cmax));
        else if ($signed(acc_m) < $signed(lane_cmin)) lane_nxt = longint'($signed(lane_cmin));
      end
      OP_ZERO_ACC: lane_nxt = 0;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_m  <= '0;
      done_m <= 1'b0;
    end else begin
      done_m <= lane_en;
      if (lane_en) acc_m <= lane_nxt[31:0];
    end
  end
  assign lane_acc  = acc_m;
  assign lane_done = done_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: dot product, then requant (acc*scale>>16 + zp), then signed clamp
  function automatic logic [31:0] ref_res(input int len, input bit s, input bit c,
                                          input logic [15:0] sc, input logic [15:0] zp,
                                          input logic [31:0] mn, input logic [31:0] mx);
    longint acc;
    logic [31:0] w;
    acc = 0;
    for (int i = 0; i < len; i++)
      acc += longint'($signed(opa[i])) * longint'($signed(opb[i]));
    w = acc[31:0];
    if (s) begin
      acc = ((longint'($signed(w)) * longint'(sc)) >>> 16) + longint'($signed(zp));
      w = acc[31:0];
    end
    if (c) begin
      if ($signed(w) > $signed(mx))      w = mx;
      else if ($signed(w) < $signed(mn)) w = mn;
    end
    return w;
  endfunction

  // one command end to end; abort_at >= 0 aborts after that many handshakes
  task automatic do_cmd(input string nm, input int len, input bit s, input bit c,
                        input logic [15:0] sc, input logic [15:0] zp,
                        input logic [31:0] mn, input logic [31:0] mx,
                        input logic [31:0] exp, input bit gaps, input int hold,
                        input int abort_at);
    int k, lat;
    bit bad_cr, bad_op, bad_hold, aborted, seen;
    logic [31:0] d0;
    k = 0; lat = 0; bad_cr = 0; bad_op = 0; bad_hold = 0; aborted = 0; seen = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_len = LEN_W'(len); cmd_do_scale = s; cmd_do_clamp = c;
    cmd_scale = sc; cmd_zero_pt = zp; cmd_cmin = mn; cmd_cmax = mx;
    chk({nm, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0; lat = 1;
    chk({nm, ".zero_op"}, {28'd0, lane_en, lane_op}, {28'd0, 1'b1, OP_ZERO_ACC});
    while (!res_valid && lat < 300 && !aborted) begin
      if (cmd_ready) bad_cr = 1;
      op_valid = 1'b0;
      if (op_ready) begin
        if (k >= len) bad_op = 1;
        else if (k == abort_at) begin
          abort = 1'b1; op_valid = 1'b1; op_a = opa[k]; op_b = opb[k];
          #1;
          chk({nm, ".abort_gate"}, {30'd0, op_ready, lane_en}, 32'd0);
          aborted = 1;
        end else if (!(gaps && $urandom_range(0, 2) == 0)) begin
          op_valid = 1'b1; op_a = opa[k]; op_b = opb[k]; k++;
        end
      end
      @(negedge clk);
      lat++; abort = 1'b0; op_valid = 1'b0;
    end
    if (aborted) begin
      chk({nm, ".abort_idle"}, 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (res_valid) seen = 1;
        @(negedge clk);
      end
      chk({nm, ".abort_nores"}, 32'(seen), 32'd0);
    end else if (!res_valid) begin
      chk({nm, ".timeout"}, 32'd0, 32'd1);
    end else begin
      if (!gaps) chk({nm, ".latency"}, 32'(lat), 32'(len + 3 + int'(s) + int'(c)));
      chk({nm, ".op_count"}, 32'(k), 32'(len));
      chk({nm, ".proto"}, {30'd0, bad_cr, bad_op}, 32'd0);
      d0 = res_data;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!res_valid || res_data !== d0 || cmd_ready) bad_hold = 1;
      end
      if (hold > 0) chk({nm, ".hold"}, 32'(bad_hold), 32'd0);
      res_ready = 1'b1;
      chk({nm, ".res_data"}, res_data, exp);
      chk({nm, ".err"}, 32'(err), 32'd0);
      @(negedge clk);
      res_ready = 1'b0;
      chk({nm, ".to_idle"}, {29'd0, busy, res_valid, cmd_ready}, 32'd1);
    end
  endtask

  task automatic set_ops(input int len, input int a0, input int b0, input int da, input int db);
    for (int i = 0; i < len; i++) begin
      opa[i] = 8'(a0 + da * i);
      opb[i] = 8'(b0 + db * i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int len;
    bit s, c;
    logic [15:0] sc, zp;
    logic [31:0] mn, mx, e;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0;
    cmd_do_scale = 1'b0; cmd_do_clamp = 1'b0; cmd_scale = '0; cmd_zero_pt = '0;
    cmd_cmin = '0; cmd_cmax = '0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.flags", {26'd0, res_valid, err, busy, cmd_ready, op_ready, lane_en}, 32'b000100);
    chk("rst.res_data", res_data, 32'd0);
    chk("rst.lane_op", 32'(lane_op), 32'(OP_NOP));
    chk("rst.lane_cfg", lane_cmax | lane_cmin | {lane_scale, lane_zero_pt}, 32'd0);
    rst_n = 1'b1;

    // directed cases
    set_ops(4, 1, 5, 1, 1);
    do_cmd("dot4", 4, 0, 0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd70, 0, 0, -1);
    set_ops(2, 8'h80, 8'h80, 0, 0);
    do_cmd("clamp", 2, 0, 1, 16'd0, 16'd0, -32'sd100, 32'sd100, 32'd100, 0, 0, -1);
    do_cmd("noclamp", 2, 0, 0, 16'd0, 16'd0, -32'sd100, 32'sd100, 32'd32768, 0, 0, -1);
    set_ops(1, 16, 16, 0, 0);
    do_cmd("scale", 1, 1, 0, 16'h8000, 16'd3, 32'd0, 32'd0, 32'd131, 0, 0, -1);
    do_cmd("len0", 0, 0, 0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 0, 0, -1);
    set_ops(4, 1, 5, 1, 1);
    do_cmd("gaps_hold", 4, 0, 0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd70, 1, 5, -1);

    // abort mid-stream, then a clean command must re-zero the lane
    set_ops(5, 3, 7, 1, 2);
    do_cmd("abort", 5, 0, 0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 0, 0, 2);
    set_ops(4, 1, 5, 1, 1);
    do_cmd("post_abort", 4, 0, 0, 16'd0, 16'd0, 32'd0, 32'd0, 32'd70, 0, 0, -1);

    // abort while idle blocks command acceptance for that cycle
    @(negedge clk);
    abort = 1'b1; cmd_valid = 1'b1; cmd_len = 16'd1;
    #1;
    chk("idle_abort.cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0; cmd_valid = 1'b0;
    chk("idle_abort.busy", 32'(busy), 32'd0);

    // randomized commands against the reference
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(0, 12);
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      sc = 16'($urandom); zp = 16'($urandom);
      mn = -32'($urandom_range(0, 3000));
      mx = 32'($urandom_range(0, 3000));
      for (int i = 0; i < len; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      e = ref_res(len, s, c, sc, zp, mn, mx);
      do_cmd($sformatf("rnd%0d", t), len, s, c, sc, zp, mn, mx, e,
             1'(t % 2), $urandom_range(0, 5), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
